// File: rtl/fpu_issue_ctrl_if.sv
// Handshake/bus bundle between ID/EX and the FPU issue controller.
// master = ID/EX side, slave = fpu_issue_ctrl.
interface fpu_issue_ctrl_if;
    logic       issue_valid;
    logic [4:0] fpu_ctrl;
    logic [4:0] rd_in;
    logic       flush;
    logic       issue_ready;
    logic       stall;
    logic       start;
    logic [4:0] op_out;
    logic       busy;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_to_int;
    logic       wb_illegal;

    modport master (
        output issue_valid, fpu_ctrl, rd_in, flush,
        input  issue_ready, stall, start, op_out, busy, wb_valid, wb_rd, wb_to_int, wb_illegal
    );

    modport slave (
        input  issue_valid, fpu_ctrl, rd_in, flush,
        output issue_ready, stall, start, op_out, busy, wb_valid, wb_rd, wb_to_int, wb_illegal
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: assigns per-op latency, pulses start, counts down the
// in-flight op and emits a one-cycle writeback strobe tagged with its destination.
module fpu_issue_ctrl #(
    parameter int unsigned ADD_LAT  = 2,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned FMA_LAT  = 4,
    parameter int unsigned DIV_LAT  = 16,
    parameter int unsigned SQRT_LAT = 20
) (
    input logic             clk,
    input logic             rst_n,
    fpu_issue_ctrl_if.slave bus
);

    typedef enum logic {StIdle, StExec} state_e;

    state_e     r_state, w_state_d;
    logic [4:0] r_cnt, w_cnt_d;
    logic       r_start;
    logic [4:0] r_op;
    logic [4:0] r_wb_rd;
    logic       r_wb_to_int;
    logic       r_wb_illegal;

    logic [5:0] w_lat;
    logic [4:0] w_cnt_init;
    logic       w_to_int;
    logic       w_illegal;
    logic       w_issue_ready;
    logic       w_accept;
    logic       w_wb_valid;

    // Code map: 00000 FADD, 00001 FSUB, 00010 FMUL, 00011 FDIV, 00100 FSQRT,
    // 00101-00111 FSGNJ*, 01000-01010 FEQ/FLT/FLE, 01100-01111 FCVT*, 10000 FMV_X_W,
    // 10001 FMV_W_X, 10010 FCLASS, 10100-10111 FMA family; everything else undefined.
    always_comb begin
        w_lat     = 6'd1;
        w_to_int  = 1'b0;
        w_illegal = 1'b0;
        case (bus.fpu_ctrl)
            5'b00000, 5'b00001: w_lat = 6'(ADD_LAT);
            5'b00010:           w_lat = 6'(MUL_LAT);
            5'b00011:           w_lat = 6'(DIV_LAT);
            5'b00100:           w_lat = 6'(SQRT_LAT);
            5'b10100, 5'b10101, 5'b10110, 5'b10111: w_lat = 6'(FMA_LAT);
            5'b01000, 5'b01001, 5'b01010, 5'b01100, 5'b01101, 5'b10000, 5'b10010:
                w_to_int = 1'b1;
            5'b00101, 5'b00110, 5'b00111, 5'b01110, 5'b01111, 5'b10001: ;
            default:            w_illegal = 1'b1;
        endcase
    end

    assign w_cnt_init    = 5'(w_lat - 6'd1);
    assign w_issue_ready = (r_state == StIdle) |
                           ((r_state == StExec) & (r_cnt == 5'd0) & ~bus.flush);
    assign w_accept      = bus.issue_valid & w_issue_ready & ~bus.flush;
    assign w_wb_valid    = (r_state == StExec) & (r_cnt == 5'd0) & ~bus.flush;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (r_state == StExec) begin
            if (bus.flush) begin
                w_state_d = StIdle;
                w_cnt_d   = 5'd0;
            end else if (r_cnt != 5'd0) begin
                w_cnt_d = r_cnt - 5'd1;
            end else begin
                w_state_d = StIdle;
            end
        end
        // Acceptance in the completion cycle overrides the return to idle.
        if (w_accept) begin
            w_state_d = StExec;
            w_cnt_d   = w_cnt_init;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 5'd0;
            r_start      <= 1'b0;
            r_op         <= 5'd0;
            r_wb_rd      <= 5'd0;
            r_wb_to_int  <= 1'b0;
            r_wb_illegal <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_start <= w_accept;
            if (w_accept) begin
                r_op         <= bus.fpu_ctrl;
                r_wb_rd      <= bus.rd_in;
                r_wb_to_int  <= w_to_int;
                r_wb_illegal <= w_illegal;
            end
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.stall       = bus.issue_valid & ~w_issue_ready;
    assign bus.start       = r_start;
    assign bus.op_out      = r_op;
    assign bus.busy        = (r_state == StExec);
    assign bus.wb_valid    = w_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_to_int   = r_wb_to_int;
    assign bus.wb_illegal  = r_wb_illegal;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_fpu_issue_ctrl;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(
        .ADD_LAT (2),
        .MUL_LAT (3),
        .FMA_LAT (4),
        .DIV_LAT (16),
        .SQRT_LAT(20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next cycle, apply inputs, then settle before checking.
    task automatic cyc(input logic v, input logic [4:0] op, input logic [4:0] rd, input logic fl);
        @(negedge clk);
        bus.issue_valid = v;
        bus.fpu_ctrl    = op;
        bus.rd_in       = rd;
        bus.flush       = fl;
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.issue_valid = 1'b0;
        bus.fpu_ctrl    = 5'd0;
        bus.rd_in       = 5'd0;
        bus.flush       = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_wbv", bus.wb_valid, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_op", bus.op_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.issue_ready, 1);

        // 1: FADD rd=5, LAT=2
        cyc(1, 5'b00000, 5'd5, 0);
        chk("t1_ready", bus.issue_ready, 1);
        chk("t1_stall", bus.stall, 0);
        cyc(0, 0, 0, 0);
        chk("t1_start", bus.start, 1);
        chk("t1_wbv_c1", bus.wb_valid, 0);
        chk("t1_busy", bus.busy, 1);
        cyc(0, 0, 0, 0);
        chk("t1_start_c2", bus.start, 0);
        chk("t1_wbv", bus.wb_valid, 1);
        chk("t1_wbrd", bus.wb_rd, 5);
        chk("t1_toint", bus.wb_to_int, 0);
        cyc(0, 0, 0, 0);
        chk("t1_idle", bus.busy, 0);
        chk("t1_wbv_c3", bus.wb_valid, 0);

        // 2: FDIV rd=3, then FEQ rd=7 held valid
        cyc(1, 5'b00011, 5'd3, 0);
        for (int c = 1; c <= 15; c++) begin
            cyc(1, 5'b01000, 5'd7, 0);
            chk("t2_stall", bus.stall, 1);
            chk("t2_nowb", bus.wb_valid, 0);
        end
        cyc(1, 5'b01000, 5'd7, 0);
        chk("t2_wbv16", bus.wb_valid, 1);
        chk("t2_wbrd16", bus.wb_rd, 3);
        chk("t2_ready16", bus.issue_ready, 1);
        chk("t2_stall16", bus.stall, 0);
        cyc(0, 0, 0, 0);
        chk("t2_start17", bus.start, 1);
        chk("t2_op17", bus.op_out, 5'b01000);
        chk("t2_wbv17", bus.wb_valid, 1);
        chk("t2_wbrd17", bus.wb_rd, 7);
        chk("t2_toint17", bus.wb_to_int, 1);
        cyc(0, 0, 0, 0);
        chk("t2_wbv18", bus.wb_valid, 0);
        chk("t2_busy18", bus.busy, 0);

        // 3: FSQRT flushed in cycle 5
        cyc(1, 5'b00100, 5'd9, 0);
        for (int c = 1; c <= 4; c++) cyc(0, 0, 0, 0);
        cyc(1, 5'b00000, 5'd1, 1);
        chk("t3_wbv5", bus.wb_valid, 0);
        chk("t3_ready5", bus.issue_ready, 0);
        cyc(0, 0, 0, 0);
        chk("t3_busy6", bus.busy, 0);
        chk("t3_ready6", bus.issue_ready, 1);
        for (int c = 7; c <= 20; c++) begin
            cyc(0, 0, 0, 0);
            chk("t3_nowb", bus.wb_valid, 0);
        end

        // 4: FMV_X_W every cycle, rd=1..4
        for (int i = 1; i <= 4; i++) cyc(1, 5'b10000, 5'(i), 0);
        cyc(0, 0, 0, 0);
        chk("t4_last_start", bus.start, 1);
        chk("t4_last_wbrd", bus.wb_rd, 4);
        // Re-run to observe cycles 1..4 individually.
        cyc(0, 0, 0, 0);
        cyc(1, 5'b10000, 5'd1, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) cyc(1, 5'b10000, 5'(i + 1), 0);
            else       cyc(0, 0, 0, 0);
            chk("t4_start", bus.start, 1);
            chk("t4_wbv", bus.wb_valid, 1);
            chk("t4_wbrd", bus.wb_rd, 32'(i));
            chk("t4_toint", bus.wb_to_int, 1);
        end
        cyc(0, 0, 0, 0);
        chk("t4_end", bus.wb_valid, 0);

        // 5: undefined code 11000, then legal FSGNJ rd=9
        cyc(1, 5'b11000, 5'd2, 0);
        cyc(1, 5'b00101, 5'd9, 0);
        chk("t5_wbv1", bus.wb_valid, 1);
        chk("t5_ill1", bus.wb_illegal, 1);
        cyc(0, 0, 0, 0);
        chk("t5_wbv2", bus.wb_valid, 1);
        chk("t5_ill2", bus.wb_illegal, 0);
        chk("t5_wbrd2", bus.wb_rd, 9);

        // 7: FMUL LAT=3, FMA LAT=4
        cyc(1, 5'b00010, 5'd11, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t7_mul_c2", bus.wb_valid, 0);
        cyc(0, 0, 0, 0);
        chk("t7_mul_c3", bus.wb_valid, 1);
        cyc(1, 5'b10110, 5'd12, 0);
        for (int c = 1; c <= 3; c++) cyc(0, 0, 0, 0);
        chk("t7_fma_c3", bus.wb_valid, 0);
        cyc(0, 0, 0, 0);
        chk("t7_fma_c4", bus.wb_valid, 1);
        chk("t7_fma_rd", bus.wb_rd, 12);

        // 6: reset in cycle 8 of FDIV
        cyc(1, 5'b00011, 5'd13, 0);
        for (int c = 1; c <= 7; c++) cyc(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_wbv", bus.wb_valid, 0);
        chk("t6_op", bus.op_out, 0);
        chk("t6_wbrd", bus.wb_rd, 0);
        chk("t6_start", bus.start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_ready", bus.issue_ready, 1);
        for (int c = 0; c < 12; c++) begin
            cyc(0, 0, 0, 0);
            chk("t6_nowb", bus.wb_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
